// File: rtl/bout_controller.sv
// Fencing bout sequencer: countdown, fight, pause and game-over phases with scoring.
// Optional macro DOUBLE_TOUCH_EN scores simultaneous touches for both fencers instead of annulling them.
module bout_controller #(
    parameter int WIN_SCORE        = 5,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int PAUSE_FRAMES     = 90
) (
    input  logic       clk_pixel_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       frame_tick_in,
    input  logic       action_valid_in,
    input  logic       player_scored_in,
    input  logic       opponent_scored_in,
    output logic       sync_valid_out,
    output logic [2:0] phase_out,
    output logic [7:0] frames_left_out,
    output logic [3:0] player_score_out,
    output logic [3:0] opponent_score_out,
    output logic [1:0] touch_out,
    output logic [1:0] winner_out
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

    state_t     state_r, state_s;
    logic [7:0] frames_r, frames_s;
    logic [3:0] p_score_r, p_score_s;
    logic [3:0] o_score_r, o_score_s;
    logic [1:0] touch_r, touch_s;
    logic [1:0] winner_r, winner_s;
    logic       sync_r, sync_s;
    logic       awaiting_r, awaiting_s;
    logic       hit_p_s, hit_o_s;
    logic       win_p_s, win_o_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_s    = state_r;
        frames_s   = frames_r;
        p_score_s  = p_score_r;
        o_score_s  = o_score_r;
        touch_s    = 2'b00;
        winner_s   = winner_r;
        sync_s     = 1'b0;
        awaiting_s = awaiting_r & ~action_valid_in;
        hit_p_s    = 1'b0;
        hit_o_s    = 1'b0;
        win_p_s    = 1'b0;
        win_o_s    = 1'b0;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start_in) begin
                    state_s   = ST_COUNTDOWN;
                    frames_s  = CD_LOAD;
                    p_score_s = 4'd0;
                    o_score_s = 4'd0;
                    winner_s  = 2'b00;
                end else begin
                    state_s = state_r;
                end
            end
            ST_COUNTDOWN, ST_PAUSE: begin
                if (frame_tick_in) begin
                    if (frames_r <= 8'd1) begin
                        if (state_r == ST_COUNTDOWN) begin
                            state_s  = ST_FIGHT;
                            frames_s = 8'd0;
                        end else begin
                            state_s  = ST_COUNTDOWN;
                            frames_s = CD_LOAD;
                        end
                    end else begin
                        frames_s = frames_r - 8'd1;
                    end
                end else begin
                    frames_s = frames_r;
                end
            end
            ST_FIGHT: begin
                if (action_valid_in && awaiting_r) begin
`ifdef DOUBLE_TOUCH_EN
                    hit_p_s = player_scored_in;
                    hit_o_s = opponent_scored_in;
`else
                    hit_p_s = player_scored_in & ~opponent_scored_in;
                    hit_o_s = opponent_scored_in & ~player_scored_in;
`endif
                end else begin
                    hit_p_s = 1'b0;
                    hit_o_s = 1'b0;
                end

                // A scored touch ends the fight; the simultaneous tick is then discarded.
                if (hit_p_s || hit_o_s) begin
                    p_score_s  = hit_p_s ? sat_inc(p_score_r) : p_score_r;
                    o_score_s  = hit_o_s ? sat_inc(o_score_r) : o_score_r;
                    touch_s    = {hit_o_s, hit_p_s};
                    win_p_s    = (p_score_s == WIN_VAL);
                    win_o_s    = (o_score_s == WIN_VAL);
                    awaiting_s = 1'b0;
                    if (win_p_s || win_o_s) begin
                        state_s  = ST_OVER;
                        winner_s = {win_o_s, win_p_s};
                        frames_s = 8'd0;
                    end else begin
                        state_s  = ST_PAUSE;
                        frames_s = PAUSE_LOAD;
                    end
                end else if (frame_tick_in && !awaiting_s) begin
                    sync_s     = 1'b1;
                    awaiting_s = 1'b1;
                end else begin
                    sync_s = 1'b0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                frames_s   = 8'd0;
                awaiting_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            frames_r   <= 8'd0;
            p_score_r  <= 4'd0;
            o_score_r  <= 4'd0;
            touch_r    <= 2'b00;
            winner_r   <= 2'b00;
            sync_r     <= 1'b0;
            awaiting_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            frames_r   <= frames_s;
            p_score_r  <= p_score_s;
            o_score_r  <= o_score_s;
            touch_r    <= touch_s;
            winner_r   <= winner_s;
            sync_r     <= sync_s;
            awaiting_r <= awaiting_s;
        end
    end

    assign sync_valid_out     = sync_r;
    assign phase_out          = state_r;
    assign frames_left_out    = frames_r;
    assign player_score_out   = p_score_r;
    assign opponent_score_out = o_score_r;
    assign touch_out          = touch_r;
    assign winner_out         = winner_r;

endmodule

// File: tb/tb_bout_controller.sv
// Table-driven bench for bout_controller (WIN_SCORE=2, COUNTDOWN_FRAMES=3, PAUSE_FRAMES=4).
// Expectations for the simultaneous touch follow DOUBLE_TOUCH_EN when it is defined.
module tb_bout_controller;

    logic       clk;
    logic       rst, start, tick, av, ps, os;
    logic       sync_valid;
    logic [2:0] phase;
    logic [7:0] frames_left;
    logic [3:0] p_score, o_score;
    logic [1:0] touch, winner;

    int applied;
    int miscompares;

    typedef struct {
        string      name;
        logic [5:0] in_bits;   // {rst, start, tick, av, ps, os}
        logic [2:0] phase;
        logic [7:0] frames;
        logic [3:0] p;
        logic [3:0] o;
        logic [1:0] touch;
        logic [1:0] win;
        logic       sync;
    } vec_t;

    bout_controller #(
        .WIN_SCORE(2),
        .COUNTDOWN_FRAMES(3),
        .PAUSE_FRAMES(4)
    ) dut (
        .clk_pixel_in      (clk),
        .rst_in            (rst),
        .start_in          (start),
        .frame_tick_in     (tick),
        .action_valid_in   (av),
        .player_scored_in  (ps),
        .opponent_scored_in(os),
        .sync_valid_out    (sync_valid),
        .phase_out         (phase),
        .frames_left_out   (frames_left),
        .player_score_out  (p_score),
        .opponent_score_out(o_score),
        .touch_out         (touch),
        .winner_out        (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [5:0] ib, input logic [2:0] ph,
                                input logic [7:0] fr, input logic [3:0] p, input logic [3:0] o,
                                input logic [1:0] t, input logic [1:0] w, input logic s);
        vec_t v;
        v.name = n; v.in_bits = ib; v.phase = ph; v.frames = fr;
        v.p = p; v.o = o; v.touch = t; v.win = w; v.sync = s;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        {rst, start, tick, av, ps, os} = v.in_bits;
        @(posedge clk);
        #1;
        {rst, start, tick, av, ps, os} = 6'b000000;
        applied++;
        if ({phase, frames_left, p_score, o_score, touch, winner, sync_valid} !==
            {v.phase, v.frames, v.p, v.o, v.touch, v.win, v.sync}) begin
            miscompares++;
            $display("FAIL %s: got ph=%0d fl=%0d ps=%0d os=%0d t=%b w=%b s=%b, want ph=%0d fl=%0d ps=%0d os=%0d t=%b w=%b s=%b",
                     v.name, phase, frames_left, p_score, o_score, touch, winner, sync_valid,
                     v.phase, v.frames, v.p, v.o, v.touch, v.win, v.sync);
        end
    endtask

    vec_t tbl[$];

    initial begin
        applied = 0;
        miscompares = 0;
        {rst, start, tick, av, ps, os} = 6'b000000;
        repeat (2) @(posedge clk);
        #1;

        //                 name           r s t a p o    ph    fr    p     o     t      w      s
        tbl.push_back(mk("reset",        6'b100000, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("idle_hold",    6'b000000, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("idle_tick",    6'b001000, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("idle_action",  6'b000110, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("start",        6'b010000, 3'd1, 8'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd_start_ign", 6'b010000, 3'd1, 8'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd_tick1",     6'b001000, 3'd1, 8'd2, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd_hold",      6'b000000, 3'd1, 8'd2, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd_tick2",     6'b001000, 3'd1, 8'd1, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd_to_fight",  6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("launch",       6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("launch_1cyc",  6'b000000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("drop_tick1",   6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("drop_tick2",   6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("miss_relaunch",6'b001100, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("player_touch", 6'b000110, 3'd3, 8'd4, 4'd1, 4'd0, 2'b01, 2'b00, 1'b0));
        tbl.push_back(mk("touch_1cyc",   6'b000000, 3'd3, 8'd4, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps_start_ign", 6'b010000, 3'd3, 8'd4, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps_tick1",     6'b001000, 3'd3, 8'd3, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps_tick2",     6'b001000, 3'd3, 8'd2, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps_tick3",     6'b001000, 3'd3, 8'd1, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps_to_cd",     6'b001000, 3'd1, 8'd3, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd2_tick1",    6'b001000, 3'd1, 8'd2, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd2_tick2",    6'b001000, 3'd1, 8'd1, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd2_to_fight", 6'b001000, 3'd2, 8'd0, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("unsolicited",  6'b000110, 3'd2, 8'd0, 4'd1, 4'd0, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("unsol_tick",   6'b001101, 3'd2, 8'd0, 4'd1, 4'd0, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("opp_tick_sim", 6'b001101, 3'd3, 8'd4, 4'd1, 4'd1, 2'b10, 2'b00, 1'b0));
        tbl.push_back(mk("ps2_tick1",    6'b001000, 3'd3, 8'd3, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps2_tick2",    6'b001000, 3'd3, 8'd2, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps2_tick3",    6'b001000, 3'd3, 8'd1, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("ps2_to_cd",    6'b001000, 3'd1, 8'd3, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd3_tick1",    6'b001000, 3'd1, 8'd2, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd3_tick2",    6'b001000, 3'd1, 8'd1, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("cd3_to_fight", 6'b001000, 3'd2, 8'd0, 4'd1, 4'd1, 2'b00, 2'b00, 1'b0));
        tbl.push_back(mk("launch3",      6'b001000, 3'd2, 8'd0, 4'd1, 4'd1, 2'b00, 2'b00, 1'b1));
        tbl.push_back(mk("opp_wins",     6'b000101, 3'd4, 8'd0, 4'd1, 4'd2, 2'b10, 2'b10, 1'b0));
        tbl.push_back(mk("over_hold",    6'b000000, 3'd4, 8'd0, 4'd1, 4'd2, 2'b00, 2'b10, 1'b0));
        tbl.push_back(mk("over_tick",    6'b001000, 3'd4, 8'd0, 4'd1, 4'd2, 2'b00, 2'b10, 1'b0));
        tbl.push_back(mk("over_late_av", 6'b000110, 3'd4, 8'd0, 4'd1, 4'd2, 2'b00, 2'b10, 1'b0));
        tbl.push_back(mk("over_restart", 6'b010000, 3'd1, 8'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));

        foreach (tbl[i]) apply(tbl[i]);

        // Simultaneous touch in a single result strobe.
        apply(mk("dt_cd1",   6'b001000, 3'd1, 8'd2, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("dt_cd2",   6'b001000, 3'd1, 8'd1, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("dt_fight", 6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("dt_launch",6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));
`ifdef DOUBLE_TOUCH_EN
        apply(mk("double",   6'b000111, 3'd3, 8'd4, 4'd1, 4'd1, 2'b11, 2'b00, 1'b0));
`else
        apply(mk("double",   6'b000111, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("dt_relnch",6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));
        apply(mk("dt_ptouch",6'b000110, 3'd3, 8'd4, 4'd1, 4'd0, 2'b01, 2'b00, 1'b0));
`endif
        apply(mk("ps_tick",  6'b001000, 3'd3, 8'd3, 4'd1,
`ifdef DOUBLE_TOUCH_EN
                 4'd1,
`else
                 4'd0,
`endif
                 2'b00, 2'b00, 1'b0));

        // Reset mid-pause with non-zero scores, overriding other inputs.
        apply(mk("rst_pause",6'b111111, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));

        // Reset while a request is outstanding must clear the awaiting flag.
        apply(mk("ra_start", 6'b010000, 3'd1, 8'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_cd1",   6'b001000, 3'd1, 8'd2, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_cd2",   6'b001000, 3'd1, 8'd1, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_fight", 6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_launch",6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));
        apply(mk("ra_rst",   6'b110000, 3'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_start2",6'b010000, 3'd1, 8'd3, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_cd3",   6'b001000, 3'd1, 8'd2, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_cd4",   6'b001000, 3'd1, 8'd1, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_fight2",6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0));
        apply(mk("ra_relnch",6'b001000, 3'd2, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/bout_controller.md
BOUT_CONTROLLER -- requirements
Module: bout_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, meaning touches needed to win a bout (1..15).
REQ-002 SHALL have parameter COUNTDOWN_FRAMES, default 180, meaning frames of "en garde" before fighting (1..255).
REQ-003 SHALL have parameter PAUSE_FRAMES, default 90, meaning frames of halt after a touch (1..255).
REQ-004 SHALL have port: clk_pixel_in  input  1  pixel clock, the only clock.
REQ-005 SHALL have port: rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: start_in  input  1  one-cycle pulse requesting a new bout.
REQ-007 SHALL have port: frame_tick_in  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port: action_valid_in  input  1  action FSM result strobe (its data_out_valid).
REQ-009 SHALL have port: player_scored_in  input  1  player touch; qualified by action_valid_in.
REQ-010 SHALL have port: opponent_scored_in  input  1  opponent touch; qualified by action_valid_in.
REQ-011 SHALL have port: sync_valid_out  output  1  one-cycle launch strobe to action FSM syncer_in_valid.
REQ-012 SHALL have port: phase_out  output  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 PAUSE, 4 OVER.
REQ-013 SHALL have port: frames_left_out  output  8  remaining frames in COUNTDOWN/PAUSE, else 0.
REQ-014 SHALL have port: player_score_out  output  4  player touches this bout.
REQ-015 SHALL have port: opponent_score_out  output  4  opponent touches this bout.
REQ-016 SHALL have port: touch_out  output  2  one-cycle pulse, bit0 player touch, bit1 opponent touch.
REQ-017 SHALL have port: winner_out  output  2  00 none, 01 player, 10 opponent, 11 draw.

Function
REQ-018 All outputs SHALL be registered; phase_out SHALL equal the current state.
REQ-019 IDLE: start_in SHALL move to COUNTDOWN, clear both scores and winner_out, load frames_left_out=COUNTDOWN_FRAMES.
REQ-020 COUNTDOWN/PAUSE: each frame_tick_in SHALL decrement frames_left_out; the tick seen at value 1 SHALL set it to 0 and move COUNTDOWN->FIGHT, PAUSE->COUNTDOWN (reload COUNTDOWN_FRAMES).
REQ-021 FIGHT: a frame_tick_in while not awaiting SHALL assert sync_valid_out exactly one cycle later and set an internal awaiting flag.
REQ-022 frame_tick_in while awaiting SHALL be dropped; at most one action request SHALL be outstanding.
REQ-023 action_valid_in SHALL clear awaiting in any state; its scored inputs SHALL be evaluated only in FIGHT and only when awaiting was set.
REQ-024 A single touch SHALL increment that score by 1 and pulse the matching touch_out bit in the next cycle.
REQ-025 After a touch, if any score equals WIN_SCORE the state SHALL go to OVER with winner_out set; otherwise to PAUSE with frames_left_out=PAUSE_FRAMES.
REQ-026 Scores SHALL saturate at 15 and never wrap.
REQ-027 OVER: scores and winner_out SHALL hold; start_in SHALL behave as in IDLE.
REQ-028 start_in SHALL be ignored in COUNTDOWN, FIGHT and PAUSE.
REQ-029 Simultaneous frame_tick_in and action_valid_in in FIGHT: result SHALL be processed; tick SHALL launch only if the result keeps the state in FIGHT.
REQ-030 Leaving FIGHT SHALL clear awaiting; a late action_valid_in SHALL cause no score change.

Reset
REQ-031 rst_in SHALL force IDLE, clear awaiting, and drive every output to 0 on the next clock edge, overriding all inputs, including mid-bout.

Configuration
REQ-032 Macro DOUBLE_TOUCH_EN SHALL select simultaneous-touch handling (both scored inputs high with one strobe).
REQ-033 With DOUBLE_TOUCH_EN defined: both scores SHALL increment, touch_out=11, REQ-025 applies; both reaching WIN_SCORE SHALL give winner_out=11.
REQ-034 Without DOUBLE_TOUCH_EN: the double touch SHALL be annulled: no score change, touch_out=00, state stays FIGHT.

Verification
REQ-035 Reset, start_in, COUNTDOWN_FRAMES=3, three ticks -> phase 1 with frames_left 3,2,1, then phase 2 exactly after the third tick.
REQ-036 FIGHT, tick -> sync_valid_out high one cycle later; two more ticks before action_valid_in -> no further sync_valid_out.
REQ-037 action_valid_in with player_scored_in=1 -> player_score 1, touch_out=01 one cycle, phase 3, frames_left=PAUSE_FRAMES.
REQ-038 WIN_SCORE=2, opponent scores twice -> phase 4, winner_out=10; start_in -> scores 0, winner 00, phase 1.
REQ-039 Both scored in one strobe -> with DOUBLE_TOUCH_EN scores 1/1, touch_out=11; without, scores 0/0, touch_out=00, phase 2.
REQ-040 rst_in asserted during PAUSE with scores 3/2 -> next cycle phase 0, all outputs 0.
